memory_access: RTL and testbench
================================

Name: memory_access

Overview:
Pipeline stage between execute and write-back. Drives the data-memory bus for loads and stores and formats store data with byte enables. Inserts wait states, with a timeout, until the memory acknowledges. Registers everything write-back needs: ALU result, funct3, rd, control bits and the raw memory word. Load byte/half extraction stays downstream, keyed on result[1:0].

Parameters:
TIMEOUT, 16, max cycles waiting for dmem_ack before aborting the access (must be >=1)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
valid_from_execute  input  1  instruction present in execute output register
result_from_execute  input  32  ALU result; effective address for loads/stores
rs2_from_execute  input  32  store source data
funct3_from_execute  input  3  access size/sign
rd_from_execute  input  5  destination register
write_reg_from_execute  input  1  instruction writes rd
select_from_execute  input  1  1 = load (write-back uses memory data)
mem_write_from_execute  input  1  1 = store
stall_from_memory  output  1  execute/earlier stages must hold
dmem_req  output  1  bus request, held until ack or abort
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables (all 0 on reads)
dmem_rdata  input  32  read word, valid with dmem_ack
dmem_ack  input  1  access complete, one-cycle pulse
result_from_memory  output  32  registered ALU result
funct3_from_memory  output  3  registered funct3
rd_from_memory  output  5  registered rd
out_from_memory  output  32  raw memory word of the last load (not extracted)
write_reg_from_memory  output  1  registered write enable
select_from_memory  output  1  registered load select
misaligned_from_memory  output  1  one-cycle pulse: misaligned access dropped
bus_error_from_memory  output  1  one-cycle pulse: access aborted on timeout

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE and the timeout counter to 0. Reset is immediate, so an in-flight dmem_req drops asynchronously.
- mem_op = valid & (select | mem_write). Non-mem valid instruction: 1-cycle pass-through. Output registers load the execute fields, out_from_memory holds its value, and there is no stall.
- Invalid input: output registers load a bubble (write_reg=0, select=0, other fields don't-care but registered).
- Misalignment is checked on addr[1:0]:
  - halfword (funct3[1:0]=01): misaligned when addr[0]=1
  - word (10): misaligned when addr[1:0]!=0
  - byte: never misaligned
- Misaligned mem_op: no bus request, no stall. Bubble goes to write-back and misaligned pulses for 1 cycle.
- Store formatting:
  - SB: wdata={4{rs2[7:0]}}, be=0001<<addr[1:0]
  - SH: wdata={2{rs2[15:0]}}, be=0011<<addr[1:0]
  - SW: wdata=rs2, be=1111
- FSM states are IDLE and BUSY.
  - IDLE, aligned mem_op: stall=1 combinationally. Next edge: register dmem_addr/we/wdata/be, dmem_req=1, counter=0, go BUSY. Output registers load a bubble.
  - BUSY: stall=1 and dmem_req held with stable address/data.
  - BUSY, dmem_ack=1: dmem_req=0 next edge and stall=0 this cycle, so execute advances next edge. Output registers load the held instruction fields; loads also latch out_from_memory<=dmem_rdata. Go IDLE.
  - BUSY, no ack, counter==TIMEOUT-1: abort. dmem_req=0, bubble to write-back, bus_error pulse, stall=0, go IDLE. Otherwise counter+1.
- Execute holds all inputs stable while stall=1; the block samples them only in IDLE and at completion.
- Back-to-back mem ops: each takes 1 issue cycle + wait cycles. No overlap, at most one outstanding access.
- An ack arriving in IDLE is ignored.
- Store completion: write_reg follows the input (normally 0); out_from_memory is unchanged.

Test Plan:
- ALU op: valid, result=0x1234, rd=5, write_reg=1 -> next cycle result_from_memory=0x1234, rd_from_memory=5, write_reg_from_memory=1, stall never 1.
- LW addr 0x100, ack 2 cycles after req -> dmem_addr=0x100, be=0000, stall high 3 cycles; then out_from_memory=rdata, select=1, write_reg=1.
- SB rs2=0xAABBCCDD addr 0x203, ack 1 cycle after req -> dmem_we=1, dmem_addr=0x200, be=1000, wdata=0xDDDDDDDD.
- SH at 0x101 -> no dmem_req, misaligned pulses once, write_reg_from_memory=0, stall=0.
- LW with ack never asserted, TIMEOUT=4 -> req high 4 cycles, bus_error pulses once, bubble out, next instruction proceeds.
- Reset asserted in BUSY -> dmem_req and all outputs 0 immediately; after release, a late ack in IDLE causes no output change.

Source files
------------

// File: rtl/memory_access.sv
// Memory pipeline stage: issues data-memory accesses with wait states and a timeout,
// and registers the instruction fields that write-back needs.
module memory_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_from_execute,
    input  logic [31:0] result_from_execute,
    input  logic [31:0] rs2_from_execute,
    input  logic [2:0]  funct3_from_execute,
    input  logic [4:0]  rd_from_execute,
    input  logic        write_reg_from_execute,
    input  logic        select_from_execute,
    input  logic        mem_write_from_execute,
    output logic        stall_from_memory,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] result_from_memory,
    output logic [2:0]  funct3_from_memory,
    output logic [4:0]  rd_from_memory,
    output logic [31:0] out_from_memory,
    output logic        write_reg_from_memory,
    output logic        select_from_memory,
    output logic        misaligned_from_memory,
    output logic        bus_error_from_memory
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_r;
    logic [CW-1:0] count_r;
    logic          mem_op_s;
    logic          misaligned_s;
    logic          issue_s;
    logic          wait_s;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   is_misaligned = a[0];
            2'b10:   is_misaligned = (a != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a,
                                            input logic we);
        if (!we) begin
            store_be = 4'b0000;
        end else begin
            case (f3[1:0])
                2'b00:   store_be = 4'b0001 << a;
                2'b01:   store_be = 4'b0011 << a;
                default: store_be = 4'b1111;
            endcase
        end
    endfunction

    // Replicate the store lanes so the byte enables alone select the target bytes.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   store_wdata = {4{rs2[7:0]}};
            2'b01:   store_wdata = {2{rs2[15:0]}};
            default: store_wdata = rs2;
        endcase
    endfunction

    // Access decode and stall; stall is forced low while reset holds the FSM in IDLE.
    always_comb begin
        mem_op_s          = valid_from_execute & (select_from_execute | mem_write_from_execute);
        misaligned_s      = mem_op_s & is_misaligned(funct3_from_execute, result_from_execute[1:0]);
        issue_s           = (state_r == IDLE) & mem_op_s & ~misaligned_s;
        wait_s            = (state_r == BUSY) & ~dmem_ack & (count_r != LAST_WAIT);
        stall_from_memory = rst & (issue_s | wait_s);
    end

    // Access FSM, bus drive and write-back output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r                <= IDLE;
            count_r                <= '0;
            dmem_req               <= 1'b0;
            dmem_we                <= 1'b0;
            dmem_addr              <= 32'h0000_0000;
            dmem_wdata             <= 32'h0000_0000;
            dmem_be                <= 4'b0000;
            result_from_memory     <= 32'h0000_0000;
            funct3_from_memory     <= 3'b000;
            rd_from_memory         <= 5'd0;
            out_from_memory        <= 32'h0000_0000;
            write_reg_from_memory  <= 1'b0;
            select_from_memory     <= 1'b0;
            misaligned_from_memory <= 1'b0;
            bus_error_from_memory  <= 1'b0;
        end else begin
            // Bubble by default; fields are captured every cycle but only meaningful when valid.
            result_from_memory     <= result_from_execute;
            funct3_from_memory     <= funct3_from_execute;
            rd_from_memory         <= rd_from_execute;
            write_reg_from_memory  <= 1'b0;
            select_from_memory     <= 1'b0;
            misaligned_from_memory <= 1'b0;
            bus_error_from_memory  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (valid_from_execute && !mem_op_s) begin
                        write_reg_from_memory <= write_reg_from_execute;
                        select_from_memory    <= select_from_execute;
                    end else if (misaligned_s) begin
                        misaligned_from_memory <= 1'b1;
                    end else if (issue_s) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write_from_execute;
                        dmem_addr  <= {result_from_execute[31:2], 2'b00};
                        dmem_wdata <= store_wdata(funct3_from_execute, rs2_from_execute);
                        dmem_be    <= store_be(funct3_from_execute, result_from_execute[1:0],
                                               mem_write_from_execute);
                        count_r    <= '0;
                        state_r    <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req              <= 1'b0;
                        write_reg_from_memory <= write_reg_from_execute;
                        select_from_memory    <= select_from_execute;
                        if (select_from_execute) begin
                            out_from_memory <= dmem_rdata;
                        end else begin
                            out_from_memory <= out_from_memory;
                        end
                        state_r <= IDLE;
                    end else if (count_r == LAST_WAIT) begin
                        dmem_req              <= 1'b0;
                        bus_error_from_memory <= 1'b1;
                        state_r               <= IDLE;
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a transaction-level model predicts every output each cycle,
// and hand-computed literals pin the key scenarios.
module tb_memory_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v_in = 1'b0, wr_in = 1'b0, sel_in = 1'b0, mw_in = 1'b0;
    logic [31:0] res_in = 32'h0, rs2_in = 32'h0;
    logic [2:0]  f3_in = 3'b000;
    logic [4:0]  rd_in = 5'd0;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] result_o, out_o;
    logic [2:0]  funct3_o;
    logic [4:0]  rd_o;
    logic        wr_o, sel_o, mis_o, berr_o;

    int          errors = 0;
    int          checks = 0;
    int          ack_delay = 0;
    logic [31:0] rdata_cfg = 32'h0;
    logic        late_ack = 1'b0;

    memory_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .valid_from_execute(v_in), .result_from_execute(res_in), .rs2_from_execute(rs2_in),
        .funct3_from_execute(f3_in), .rd_from_execute(rd_in),
        .write_reg_from_execute(wr_in), .select_from_execute(sel_in),
        .mem_write_from_execute(mw_in),
        .stall_from_memory(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .result_from_memory(result_o), .funct3_from_memory(funct3_o), .rd_from_memory(rd_o),
        .out_from_memory(out_o), .write_reg_from_memory(wr_o), .select_from_memory(sel_o),
        .misaligned_from_memory(mis_o), .bus_error_from_memory(berr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the stage is doing, in transaction terms.
    typedef struct packed {
        logic        busy;
        logic [7:0]  waited;
        logic [31:0] h_res;
        logic [2:0]  h_f3;
        logic [4:0]  h_rd;
        logic        h_wr, h_sel;
        logic        req, we;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        fv;
        logic [31:0] res;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        wr, sel;
        logic [31:0] outw;
        logic        mis, berr;
    } model_t;

    model_t m;

    function automatic logic access_ok(input logic [2:0] f3, input logic [31:0] a);
        int size_bytes;
        size_bytes = (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 1;
        return (a % size_bytes) == 0;
    endfunction

    function automatic logic exp_stall(input model_t e, input logic ack);
        logic is_mem;
        is_mem = v_in && (sel_in || mw_in);
        if (!e.busy) return is_mem && access_ok(f3_in, res_in);
        return !ack && (int'(e.waited) + 1 != TO);
    endfunction

    function automatic model_t predict(input model_t e, input logic ack, input logic [31:0] rdata);
        model_t n;
        logic   is_mem;
        int     off;
        n = e;
        n.fv = 1'b0; n.wr = 1'b0; n.sel = 1'b0; n.mis = 1'b0; n.berr = 1'b0;
        is_mem = v_in && (sel_in || mw_in);
        off = int'(res_in % 4);
        if (!e.busy) begin
            if (v_in && !is_mem) begin
                n.fv = 1'b1; n.res = res_in; n.f3 = f3_in; n.rd = rd_in;
                n.wr = wr_in; n.sel = sel_in;
            end else if (is_mem && !access_ok(f3_in, res_in)) begin
                n.mis = 1'b1;
            end else if (is_mem) begin
                n.busy = 1'b1; n.waited = 8'd0; n.req = 1'b1; n.we = mw_in;
                n.addr = res_in - (res_in % 4);
                n.h_res = res_in; n.h_f3 = f3_in; n.h_rd = rd_in; n.h_wr = wr_in; n.h_sel = sel_in;
                if (!mw_in) n.be = 4'd0;
                else if (f3_in[1:0] == 2'd0) n.be = 4'(1 << off);
                else if (f3_in[1:0] == 2'd1) n.be = 4'(3 << off);
                else n.be = 4'd15;
                if (f3_in[1:0] == 2'd0) n.wdata = (rs2_in % 256) * 32'h0101_0101;
                else if (f3_in[1:0] == 2'd1) n.wdata = (rs2_in % 65536) * 32'h0001_0001;
                else n.wdata = rs2_in;
            end
        end else if (ack) begin
            n.busy = 1'b0; n.req = 1'b0; n.fv = 1'b1;
            n.res = e.h_res; n.f3 = e.h_f3; n.rd = e.h_rd; n.wr = e.h_wr; n.sel = e.h_sel;
            if (e.h_sel) n.outw = rdata;
        end else if (int'(e.waited) + 1 == TO) begin
            n.busy = 1'b0; n.req = 1'b0; n.berr = 1'b1;
        end else begin
            n.waited = e.waited + 8'd1;
        end
        return n;
    endfunction

    // Advance the model on every clock edge, cleared by the same async reset as the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else      m <= predict(m, dmem_ack, dmem_rdata);
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("stall", {31'd0, stall}, {31'd0, exp_stall(m, dmem_ack)});
            chk("dmem_req", {31'd0, dmem_req}, {31'd0, m.req});
            if (m.req) begin
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, m.we});
                chk("dmem_addr", dmem_addr, m.addr);
                chk("dmem_be", {28'd0, dmem_be}, {28'd0, m.be});
                if (m.we) chk("dmem_wdata", dmem_wdata, m.wdata);
            end
            chk("write_reg", {31'd0, wr_o}, {31'd0, m.wr});
            chk("select", {31'd0, sel_o}, {31'd0, m.sel});
            chk("misaligned", {31'd0, mis_o}, {31'd0, m.mis});
            chk("bus_error", {31'd0, berr_o}, {31'd0, m.berr});
            chk("out", out_o, m.outw);
            if (m.fv) begin
                chk("result", result_o, m.res);
                chk("funct3", {29'd0, funct3_o}, {29'd0, m.f3});
                chk("rd", {27'd0, rd_o}, {27'd0, m.rd});
            end
        end else begin
            chk("rst_zero", {stall, dmem_req, dmem_we, dmem_be, wr_o, sel_o, mis_o, berr_o,
                             funct3_o, rd_o}, 32'd0);
            chk("rst_zero_data", dmem_addr | dmem_wdata | result_o | out_o, 32'd0);
        end
    end

    // Memory responder: acks ack_delay cycles after the request rises, or a forced stray ack.
    initial begin
        int cnt;
        cnt = 0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (late_ack) begin
                dmem_ack = 1'b1;
                dmem_rdata = 32'hDEAD_BEEF;
                late_ack = 1'b0;
            end else if (dmem_req && cnt == ack_delay) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdata_cfg;
                cnt++;
            end else begin
                dmem_ack = 1'b0;
                cnt = dmem_req ? cnt + 1 : 0;
            end
        end
    end

    task automatic run(input logic v, input logic [31:0] res, input logic [31:0] rs2,
                       input logic [2:0] f3, input logic [4:0] rd, input logic wr,
                       input logic sel, input logic mw, input int delay, input logic [31:0] rdata,
                       output int n_stall, output int n_req, output logic [31:0] c_addr,
                       output logic c_we, output logic [31:0] c_wdata, output logic [3:0] c_be);
        logic done;
        v_in = v; res_in = res; rs2_in = rs2; f3_in = f3; rd_in = rd;
        wr_in = wr; sel_in = sel; mw_in = mw;
        ack_delay = delay; rdata_cfg = rdata;
        n_stall = 0; n_req = 0; done = 1'b0;
        c_addr = 32'h0; c_we = 1'b0; c_wdata = 32'h0; c_be = 4'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dmem_req) begin
                if (n_req == 0) begin
                    c_addr = dmem_addr; c_we = dmem_we; c_wdata = dmem_wdata; c_be = dmem_be;
                end
                n_req++;
            end
            if (!stall) begin
                done = 1'b1;
                break;
            end
            n_stall++;
        end
        chk("run_completes", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        v_in = 1'b0; wr_in = 1'b0; sel_in = 1'b0; mw_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          ns, nr;
        logic [31:0] ca, cw;
        logic        cwe;
        logic [3:0]  cbe;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_req", {31'd0, dmem_req}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // ALU pass-through
        run(1'b1, 32'h1234, 32'h0, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'h0, ns, nr, ca, cwe, cw, cbe);
        chk("alu_stall", ns, 0);
        chk("alu_result", result_o, 32'h1234);
        chk("alu_rd", {27'd0, rd_o}, 32'd5);
        chk("alu_wr", {31'd0, wr_o}, 32'd1);

        // LW 0x100, ack two cycles after request
        run(1'b1, 32'h100, 32'h0, 3'b010, 5'd7, 1'b1, 1'b1, 1'b0, 2, 32'hCAFE_F00D, ns, nr, ca, cwe, cw, cbe);
        chk("lw_stall", ns, 3);
        chk("lw_addr", ca, 32'h100);
        chk("lw_be", {28'd0, cbe}, 32'd0);
        chk("lw_out", out_o, 32'hCAFE_F00D);
        chk("lw_sel", {31'd0, sel_o}, 32'd1);
        chk("lw_wr", {31'd0, wr_o}, 32'd1);

        // SB 0xAABBCCDD at 0x203, back-to-back after the load
        run(1'b1, 32'h203, 32'hAABB_CCDD, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1, 32'h0, ns, nr, ca, cwe, cw, cbe);
        chk("sb_we", {31'd0, cwe}, 32'd1);
        chk("sb_addr", ca, 32'h200);
        chk("sb_be", {28'd0, cbe}, 32'h8);
        chk("sb_wdata", cw, 32'hDDDD_DDDD);
        chk("sb_out_kept", out_o, 32'hCAFE_F00D);

        // SH misaligned at 0x101
        run(1'b1, 32'h101, 32'h1111, 3'b001, 5'd0, 1'b0, 1'b0, 1'b1, 0, 32'h0, ns, nr, ca, cwe, cw, cbe);
        chk("shmis_req", nr, 0);
        chk("shmis_stall", ns, 0);
        chk("shmis_pulse", {31'd0, mis_o}, 32'd1);
        chk("shmis_wr", {31'd0, wr_o}, 32'd0);
        idle(1);
        chk("shmis_once", {31'd0, mis_o}, 32'd0);

        // SH aligned at 0x102, immediate ack
        run(1'b1, 32'h102, 32'h1122_3344, 3'b001, 5'd0, 1'b0, 1'b0, 1'b1, 0, 32'h0, ns, nr, ca, cwe, cw, cbe);
        chk("sh_be", {28'd0, cbe}, 32'hC);
        chk("sh_wdata", cw, 32'h3344_3344);

        // LB at 0x305: word address, raw word returned
        run(1'b1, 32'h305, 32'h0, 3'b100, 5'd9, 1'b1, 1'b1, 1'b0, 0, 32'h5566_7788, ns, nr, ca, cwe, cw, cbe);
        chk("lb_addr", ca, 32'h304);
        chk("lb_out", out_o, 32'h5566_7788);
        chk("lb_funct3", {29'd0, funct3_o}, 32'd4);
        chk("lb_result", result_o, 32'h305);

        // LW misaligned at 0x106
        run(1'b1, 32'h106, 32'h0, 3'b010, 5'd3, 1'b1, 1'b1, 1'b0, 0, 32'h0, ns, nr, ca, cwe, cw, cbe);
        chk("lwmis_pulse", {31'd0, mis_o}, 32'd1);
        chk("lwmis_req", nr, 0);

        // LW timeout, then an ALU op proceeds
        run(1'b1, 32'h400, 32'h0, 3'b010, 5'd4, 1'b1, 1'b1, 1'b0, 99, 32'h0, ns, nr, ca, cwe, cw, cbe);
        chk("to_req_cycles", nr, TO);
        chk("to_berr", {31'd0, berr_o}, 32'd1);
        chk("to_wr", {31'd0, wr_o}, 32'd0);
        chk("to_out_kept", out_o, 32'h5566_7788);
        run(1'b1, 32'h55, 32'h0, 3'b000, 5'd6, 1'b1, 1'b0, 1'b0, 0, 32'h0, ns, nr, ca, cwe, cw, cbe);
        chk("to_berr_once", {31'd0, berr_o}, 32'd0);
        chk("after_to_result", result_o, 32'h55);
        idle(1);
        chk("bubble_wr", {31'd0, wr_o}, 32'd0);

        // Reset while BUSY, then a stray ack in IDLE
        v_in = 1'b1; res_in = 32'h300; f3_in = 3'b010; rd_in = 5'd2;
        wr_in = 1'b1; sel_in = 1'b1; mw_in = 1'b0; ack_delay = 99;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("busy_req", {31'd0, dmem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_req", {31'd0, dmem_req}, 32'd0);
        chk("async_stall", {31'd0, stall}, 32'd0);
        chk("async_out", out_o, 32'd0);
        idle(2);
        rst = 1'b1;
        late_ack = 1'b1;
        idle(3);
        chk("late_ack_out", out_o, 32'd0);
        chk("late_ack_wr", {31'd0, wr_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
